// File: rtl/pwm_multi.sv
// Multi-channel PWM modulator with double-buffered duty loading, optional
// first-order error-feedback noise shaping and edge- or centre-aligned output.
// Duty registers update only on the last cycle of each period (count == N-1).
module pwm_multi #(
  parameter int SAMPLE_W    = 24,
  parameter int CNT_W       = 5,
  parameter int CHANNELS    = 2,
  parameter int NOISE_SHAPE = 1,
  parameter int CENTER      = 0
) (
  input  logic                         mck,
  input  logic                         rst,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample,
  input  logic                         sample_valid,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CNT_W-1:0]             count,
  output logic                         frame
);

  // Bits dropped when reducing a sample to a duty value.
  localparam int RES_W = SAMPLE_W - CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Period length N, held at CNT_W+1 bits so duty == N is representable.
  localparam logic [CNT_W:0] N_FULL = {1'b1, {CNT_W{1'b0}}};

  logic [CNT_W:0] count_x;

  // Free-running phase counter shared by all channels; wraps N-1 -> 0.
  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Period-boundary marker decoded from the registered counter.
  assign frame   = (count == CNT_MAX);
  assign count_x = {1'b0, count};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SAMPLE_W-1:0] shadow;
    logic [SAMPLE_W-1:0] src;
    logic [SAMPLE_W:0]   sum;
    logic [CNT_W:0]      duty;
    logic [RES_W-1:0]    residual;
    logic [CNT_W:0]      half;
    logic [CNT_W:0]      low_len;

    // Shadow register: every valid write lands here, so the last write of a
    // period is what the next boundary picks up.
    always_ff @(posedge mck or posedge rst) begin
      if (rst) begin
        shadow <= '0;
      end else if (sample_valid) begin
        shadow <= sample[c*SAMPLE_W +: SAMPLE_W];
      end
    end

    // A write on the boundary cycle itself bypasses the shadow so it still
    // makes the very next period.
    assign src = sample_valid ? sample[c*SAMPLE_W +: SAMPLE_W] : shadow;
    // One extra bit absorbs the carry; src + residual cannot exceed it.
    assign sum = {1'b0, src} + {{(CNT_W+1){1'b0}}, residual};

    // Duty and truncation residual change only at the period boundary.
    always_ff @(posedge mck or posedge rst) begin
      if (rst) begin
        duty     <= '0;
        residual <= '0;
      end else if (frame) begin
        duty     <= sum[SAMPLE_W:RES_W];
        residual <= (NOISE_SHAPE != 0) ? sum[RES_W-1:0] : '0;
      end
    end

    // Centre mode splits the high time into a leading run of low_len cycles
    // and a trailing run of half cycles; the two meet across the wrap.
    assign half    = duty >> 1;
    assign low_len = duty - half;

    if (CENTER != 0) begin : g_center
      assign pwm_out[c] = (count_x < low_len) || (count_x >= (N_FULL - half));
    end else begin : g_edge
      assign pwm_out[c] = (count_x < duty);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: three instances (noise-shaped edge, plain edge,
// noise-shaped centre) share one stimulus stream and are compared every
// cycle against an integer per-period model, plus directed period checks.
module tb_pwm_multi;

  localparam int N       = 32;
  localparam int RES_DIV = 1 << 19;

  logic        mck = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] sample = '0;
  logic        sample_valid = 1'b0;

  logic [1:0] pwm0, pwm1, pwm2;
  logic [4:0] count0, count1, count2;
  logic       frame0, frame1, frame2;

  pwm_multi #(.NOISE_SHAPE(1), .CENTER(0)) u_ns (
    .mck(mck), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .pwm_out(pwm0), .count(count0), .frame(frame0));

  pwm_multi #(.NOISE_SHAPE(0), .CENTER(0)) u_pl (
    .mck(mck), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .pwm_out(pwm1), .count(count1), .frame(frame1));

  pwm_multi #(.NOISE_SHAPE(1), .CENTER(1)) u_ctr (
    .mck(mck), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .pwm_out(pwm2), .count(count2), .frame(frame2));

  always #5 mck = ~mck;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_cnt;
  int m_shadow [2];
  int m_duty   [3][2];
  int m_res    [3][2];

  // Per-period capture
  int          hi [3][2];
  logic [31:0] mk [3][2];

  typedef struct {
    logic [23:0] s0, s1;
    logic [31:0] e0, e1;   // edge-aligned patterns (bit k = level at count k)
    logic [31:0] c0, c1;   // centre-aligned patterns
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ch(input logic [47:0] s, input int c);
    logic [23:0] v;
    v = (c == 0) ? s[23:0] : s[47:24];
    return int'(v);
  endfunction

  function automatic logic exp_pwm(input int i, input int c);
    int d, h, l;
    d = m_duty[i][c];
    h = d / 2;
    l = d - h;
    if (i == 2) return (m_cnt < l) || (m_cnt >= N - h);
    return m_cnt < d;
  endfunction

  function automatic logic [7:0] obs(input int i);
    case (i)
      0:       return {count0, frame0, pwm0};
      1:       return {count1, frame1, pwm1};
      default: return {count2, frame2, pwm2};
    endcase
  endfunction

  function automatic logic pwm_of(input int i, input int c);
    logic [7:0] o;
    o = obs(i);
    return o[c];
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_shadow[c] = 0;
      for (int i = 0; i < 3; i++) begin
        m_duty[i][c] = 0;
        m_res[i][c]  = 0;
      end
    end
  endtask

  task automatic model_edge(input logic [47:0] s, input logic v);
    int src, sum;
    if (m_cnt == N - 1) begin
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          src = v ? ch(s, c) : m_shadow[c];
          sum = src + m_res[i][c];
          m_duty[i][c] = sum / RES_DIV;
          m_res[i][c]  = (i != 1) ? sum % RES_DIV : 0;
        end
      end
    end
    if (v) begin
      for (int c = 0; c < 2; c++) m_shadow[c] = ch(s, c);
    end
    m_cnt = (m_cnt + 1) % N;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      e = {5'(m_cnt), m_cnt == N - 1, exp_pwm(i, 1), exp_pwm(i, 0)};
      chk($sformatf("%s_dut%0d", tag, i), obs(i), e);
    end
  endtask

  task automatic tick(input logic [47:0] s, input logic v);
    sample       = s;
    sample_valid = v;
    @(posedge mck);
    model_edge(s, v);
    #1;
    check_all("cyc");
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases on
  // a falling edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(posedge mck);
    #1 check_all("rst_hold");
    @(negedge mck);
    sample_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic sync_to(input int t);
    for (int g = 0; g < 2 * N && m_cnt != t; g++) tick('0, 1'b0);
    chk("sync", 64'(m_cnt), 64'(t));
  endtask

  // Observes one full period starting at count 0; the first edge may carry a write.
  task automatic run_period(input logic [47:0] s0, input logic v0);
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++) begin
        hi[i][c] = 0;
        mk[i][c] = '0;
      end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < 2; c++)
          if (pwm_of(i, c)) begin
            hi[i][c]++;
            mk[i][c][k] = 1'b1;
          end
      if (k == 0) tick(s0, v0);
      else        tick('0, 1'b0);
    end
  endtask

  task automatic load_at_boundary(input logic [23:0] s1, input logic [23:0] s0);
    sync_to(N - 1);
    tick({s1, s0}, 1'b1);
  endtask

  initial begin
    int d4 [4];
    logic [63:0] r;
    logic [47:0] s;

    tbl[0] = '{24'h800000, 24'h800000, 32'h0000ffff, 32'h0000ffff, 32'hff0000ff, 32'hff0000ff};
    tbl[1] = '{24'h000000, 24'hffffff, 32'h00000000, 32'h7fffffff, 32'h00000000, 32'hfffeffff};
    tbl[2] = '{24'h080000, 24'hf80000, 32'h00000001, 32'h7fffffff, 32'h00000001, 32'hfffeffff};
    tbl[3] = '{24'h400000, 24'hc00000, 32'h000000ff, 32'h00ffffff, 32'hf000000f, 32'hfff00fff};
    tbl[4] = '{24'h600000, 24'h100000, 32'h00000fff, 32'h00000003, 32'hfc00003f, 32'h80000001};

    model_reset();
    do_reset();

    // First period after reset stays low; the write lands in the second.
    run_period({2{24'h800000}}, 1'b1);
    chk("first_period_low", 64'(hi[1][0]), 64'd0);
    run_period('0, 1'b0);
    chk("mid_duty_hi", 64'(hi[1][0]), 64'd16);
    chk("mid_edge_mask", 64'(mk[1][0]), 64'h0000ffff);
    chk("mid_ctr_mask", 64'(mk[2][1]), 64'hff0000ff);
    for (int k = 0; k < 5; k++) tick('0, 1'b0);
    chk("pre_rst_high", 64'({pwm0, pwm1}), 64'hf);
    do_reset();

    // Table of single loads with residual starting from zero.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      load_at_boundary(tbl[t].s1, tbl[t].s0);
      run_period('0, 1'b0);
      chk($sformatf("tbl%0d_e0", t), 64'(mk[1][0]), 64'(tbl[t].e0));
      chk($sformatf("tbl%0d_e1", t), 64'(mk[1][1]), 64'(tbl[t].e1));
      chk($sformatf("tbl%0d_c0", t), 64'(mk[2][0]), 64'(tbl[t].c0));
      chk($sformatf("tbl%0d_c1", t), 64'(mk[2][1]), 64'(tbl[t].c1));
    end

    // Full-scale with noise shaping reaches 32 and stays full across the wrap.
    do_reset();
    load_at_boundary(24'hffffff, 24'h000000);
    run_period('0, 1'b0);
    chk("fs_p1_ns", 64'(hi[0][1]), 64'd31);
    chk("fs_p1_pl", 64'(hi[1][1]), 64'd31);
    chk("fs_p1_ch0", 64'(hi[0][0]), 64'd0);
    run_period('0, 1'b0);
    chk("fs_p2_ns", 64'(hi[0][1]), 64'd32);
    chk("fs_p2_pl", 64'(hi[1][1]), 64'd31);
    chk("fs_p2_ctr", 64'(mk[2][1]), 64'hffffffff);
    run_period('0, 1'b0);
    chk("fs_p3_ns", 64'(hi[0][1]), 64'd32);

    // Small sample: residual accumulates to one duty step every fourth period.
    d4 = '{0, 0, 0, 1};
    do_reset();
    load_at_boundary(24'h000000, 24'h020000);
    for (int p = 0; p < 4; p++) begin
      run_period('0, 1'b0);
      chk($sformatf("small_ns_p%0d", p), 64'(hi[0][0]), 64'(d4[p]));
      chk($sformatf("small_pl_p%0d", p), 64'(hi[1][0]), 64'd0);
    end

    // Last write wins, boundary bypass, and a count==0 write waits a period.
    do_reset();
    sync_to(3);
    tick({2{24'h400000}}, 1'b1);
    sync_to(10);
    tick({2{24'hc00000}}, 1'b1);
    load_at_boundary(24'h600000, 24'h600000);
    run_period({2{24'h000000}}, 1'b1);
    chk("bypass_duty", 64'(hi[1][0]), 64'd12);
    chk("bypass_duty_ns", 64'(hi[0][1]), 64'd12);
    run_period('0, 1'b0);
    chk("late_write", 64'(hi[1][0]), 64'd0);

    // Randomised traffic, biased towards the extremes now and then.
    for (int n = 0; n < 3000; n++) begin
      r = {$urandom, $urandom};
      s = r[47:0];
      case ($urandom % 8)
        0: s[23:0]  = 24'hffffff;
        1: s[47:24] = 24'h000000;
        2: s = {24'h800000, 24'hffffff};
        default: ;
      endcase
      tick(s, ($urandom % 6) == 0);
      if (n == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM modulator. It converts offset-binary audio samples into fixed-period pulse-width streams, one per channel, clocked from the master clock. It adds three things to the single-channel PWM:
- double-buffered sample loading at period boundaries;
- optional first-order error-feedback noise shaping of the truncated sample LSBs;
- a centre-aligned output mode.

It sits between the sample-processing path and the output pins.

## Interface

Parameters:
- SAMPLE_W, 24: sample width per channel, offset binary (midscale = 1 << (SAMPLE_W-1)).
- CNT_W, 5: phase counter width; PWM period N = 2^CNT_W mck cycles.
- CHANNELS, 2: number of independent output channels.
- NOISE_SHAPE, 1: 1 feeds truncation residual back into the next period; 0 plain truncation.
- CENTER, 0: 0 edge-aligned output, 1 centre-aligned output.

Ports:
- mck  input  1  master clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- sample  input  CHANNELS*SAMPLE_W  packed samples; channel c at bits [c*SAMPLE_W +: SAMPLE_W].
- sample_valid  input  1  sample bus holds new data this cycle (all channels together).
- pwm_out  output  CHANNELS  PWM bit per channel.
- count  output  CNT_W  shared phase counter.
- frame  output  1  one-cycle pulse while count == N-1 (last cycle of period).

## Operation

Reset (asynchronous on rst high):
- count = 0, frame = 0, pwm_out = 0.
- All shadow samples, duty registers and residuals = 0.

Phase counter:
- count increments every mck and wraps N-1 -> 0.
- frame = (count == N-1), decoded from registered count.

Sample capture:
- Each mck edge with sample_valid = 1 writes every channel's shadow register.
- Multiple writes within one period: the last one wins.

Duty load, at the edge where count == N-1, per channel:
- src = sample if sample_valid is high that cycle (bypass), else shadow.
- sum = src + residual, computed at SAMPLE_W+1 bits; no overflow is possible.
- duty = sum >> (SAMPLE_W-CNT_W), CNT_W+1 bits, range 0..N.
- residual = sum[SAMPLE_W-CNT_W-1:0] when NOISE_SHAPE=1, else 0.
- duty and residual do not change at any other edge.

Output decode, combinational from registered count and duty:
- CENTER=0: pwm_out[c] = (count < duty[c]).
- CENTER=1: with h = duty >> 1 and l = duty - h, pwm_out[c] = (count < l) or (count >= N - h).
- In both modes, exactly duty[c] high cycles per period.
- duty = 0 gives constant low; duty = N gives constant high, with no glitch at the wrap.

## Timing

- Sample presented with sample_valid at any cycle of period k takes effect in period k+1, which starts at the count == 0 cycle.
- Minimum latency is 1 cycle: sample_valid at count == N-1 -> duty live at count == 0 on the next cycle.
- Sample presented at count == 0 waits N cycles.
- Reset mid-period: outputs go low immediately. After release, count starts at 0 with duty 0, so the first period is all low. The first loaded sample affects the second period.
- Channels are fully independent except for the shared count, frame and sample_valid.
- pwm_out is glitch-free between mck edges only to the extent that count and duty are registered. The only combinational path is compare logic.

## Test plan

Defaults unless stated: SAMPLE_W=24, CNT_W=5 (N=32), CHANNELS=2, CENTER=0.

1. Reset, then hold sample = 800000/800000 with sample_valid pulsed once -> from the second period onward each channel is high for count 0..15 and low for 16..31. frame pulses once per 32 cycles. Asserting rst mid-period forces pwm_out = 0 and count = 0 asynchronously.
2. Load ch0 = 000000 and ch1 = ffffff with NOISE_SHAPE=0 -> ch0 is constant low. ch1 has 31 high cycles and 1 low cycle (count 31) every period.
3. Load ch1 = ffffff with NOISE_SHAPE=1 -> period duties are 31, 32, 32, ... The residual sequence starts 7ffff, 7fffe. Full-high periods show no low cycle across the wrap.
4. Load ch0 = 020000 with NOISE_SHAPE=1 -> duties repeat 0, 0, 0, 1 (residuals 20000, 40000, 60000, 0). With NOISE_SHAPE=0 the duty is always 0.
5. Set CENTER=1 and load sample = 800000 (duty 16) -> high for count 0..7 and 24..31. Duty 1 -> high only at count 0. Duty 32 -> constant high.
6. Apply 400000, then c00000 with sample_valid in the same period, then 600000 with sample_valid exactly at count == 31 -> the next period uses 600000 (duty 12), confirming last-write-wins and the bypass. A write at count == 0 is not visible until the following period.
